dm_rr_arbiter_mem: RTL
======================

// Module: dm_rr_arbiter_mem
// PURPOSE
//  Shared data memory for an N-core array, generalising the fixed four-core private-port data memory.
//  Each core drives one request channel (valid/ready, read or write) into a single-port RAM.
//  A round-robin arbiter grants one channel per cycle; read data returns one cycle later on the granted channel.
//  Sits between the core array and data storage in the multi-core processor top.
// PARAMETERS
//  N_CORES   4    number of request channels (2..16)
//  DATA_W    16   memory word width in bits
//  ADDR_W    8    address width per channel
//  DEPTH     256  words implemented (DEPTH <= 2**ADDR_W); addresses >= DEPTH are out of range
//  CNT_W     16   width of the saturating contention counter
// PORTS
//  clk          in   1              system clock, rising edge
//  rst_n        in   1              asynchronous active-low reset
//  req_valid    in   N_CORES        per-channel request valid
//  req_we       in   N_CORES        1 = write, 0 = read; qualified by req_valid
//  req_addr     in   N_CORES*ADDR_W channel i occupies bits [i*ADDR_W +: ADDR_W]
//  req_wdata    in   N_CORES*DATA_W channel i occupies bits [i*DATA_W +: DATA_W]
//  req_ready    out  N_CORES        one-hot grant; combinational from req_valid and the priority pointer
//  rsp_valid    out  N_CORES        one-cycle pulse; read data valid on that channel
//  rsp_rdata    out  N_CORES*DATA_W read data; holds last value until that channel's next read response
//  addr_err     out  1              one-cycle pulse: the previous accepted request was out of range
//  contend_cnt  out  CNT_W          cycles with two or more req_valid set; saturates at all-ones
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - ptr=0; rsp_valid=0; rsp_rdata=0; addr_err=0; contend_cnt=0.
//   - RAM contents are not reset.
//   - A read accepted in the cycle reset asserts is dropped: no rsp_valid after release.
//  Arbitration
//   - Priority search starts at ptr and wraps modulo N_CORES.
//   - The first channel with req_valid=1 gets req_ready=1; all others get 0.
//   - If no channel is valid, req_ready=0 and ptr holds.
//   - Accept = req_valid[i] & req_ready[i]. On accept, ptr <= (i+1) mod N_CORES.
//   - This bounds wait to N_CORES-1 cycles for a continuously valid channel.
//   - A requester keeps valid, we, addr and wdata stable until accepted; it may drop valid before acceptance.
//  Write
//   - On an accepted write with addr < DEPTH, the word is written at the clock edge.
//   - No response is generated for a write.
//  Read
//   - An accepted read in cycle t gives rsp_valid[i]=1 and rsp_rdata[i]=mem[addr] in cycle t+1 (latency 1).
//   - Back-to-back reads from any mix of channels sustain one per cycle.
//  Read-after-write
//   - A read accepted in the cycle after a write to the same address returns the new data.
//   - A read and a write never occur in the same cycle (single grant).
//  Out of range (addr >= DEPTH)
//   - Write: ignored.
//   - Read: rsp_valid still pulses, with rsp_rdata=0.
//   - Both cases: addr_err=1 in cycle t+1.
//  Contention counter
//   - contend_cnt increments by 1 each cycle with popcount(req_valid) >= 2.
//   - Holds at 2**CNT_W-1.
// TESTING (N_CORES=4, DATA_W=16, ADDR_W=8, DEPTH=200 unless noted)
//  1 ch2 writes 0xBEEF to addr 0x10, then ch0 reads 0x10 next cycle -> rsp_valid=4'b0001 one cycle later, rsp_rdata[0]=0xBEEF.
//  2 all 4 channels hold read valid for 8 cycles, ptr=0 -> grants 0,1,2,3,0,1,2,3; contend_cnt=8; one rsp per cycle.
//  3 ch1 and ch3 valid, ptr=2 -> ch3 granted first, then ch1; ptr ends at 2.
//  4 ch0 writes addr 0xC8 (200), then reads it -> RAM unchanged; read rsp_rdata=0; addr_err pulses after both accepts.
//  5 ch1 read accepted, rst_n low for 1 cycle at the same edge -> no rsp_valid after release; outputs zero; ptr=0.
//  6 CNT_W=4, 20 contended cycles -> contend_cnt stops at 15.

Source files
------------

// File: rtl/dm_rr_arbiter_mem.sv
// dm_rr_arbiter_mem: shared single-port data memory for an N-core array.
// Each core owns one valid/ready request channel. A rotating-priority arbiter
// grants at most one channel per cycle. Reads answer one cycle after acceptance
// on the granted channel. Out-of-range accesses raise a one-cycle addr_err.
// A saturating counter records how many cycles had competing requesters.
module dm_rr_arbiter_mem #(
    parameter int N_CORES = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CORES-1:0]          req_valid,
    input  logic [N_CORES-1:0]          req_we,
    input  logic [N_CORES*ADDR_W-1:0]   req_addr,
    input  logic [N_CORES*DATA_W-1:0]   req_wdata,
    output logic [N_CORES-1:0]          req_ready,
    output logic [N_CORES-1:0]          rsp_valid,
    output logic [N_CORES*DATA_W-1:0]   rsp_rdata,
    output logic                        addr_err,
    output logic [CNT_W-1:0]            contend_cnt
);

    localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  cand;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              gnt_we;
    logic              gnt_in_range;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;

    // RAM storage; contents survive reset
    logic [DATA_W-1:0] mem [DEPTH];

    // Rotating-priority search from ptr; the first valid channel wins the grant
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        req_ready = '0;
        for (int k = 0; k < N_CORES; k++) begin
            cand = PTR_W'((int'(ptr) + k) % N_CORES);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Pick out the winning channel's request fields
    always_comb begin
        gnt_we       = req_we[gnt_idx];
        gnt_addr     = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        gnt_wdata    = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
        gnt_in_range = int'(gnt_addr) < DEPTH;
    end

    // Accepted in-range writes update the RAM at the clock edge
    always_ff @(posedge clk) begin
        if (gnt_any && gnt_we && gnt_in_range) begin
            mem[gnt_addr] <= gnt_wdata;
        end
    end

    // Pointer advance, read responses and the out-of-range flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            addr_err  <= 1'b0;
        end else begin
            rsp_valid <= '0;
            addr_err  <= 1'b0;
            if (gnt_any) begin
                ptr      <= (int'(gnt_idx) == N_CORES-1) ? '0 : gnt_idx + 1'b1;
                addr_err <= !gnt_in_range;
                if (!gnt_we) begin
                    rsp_valid[gnt_idx] <= 1'b1;
                    // Out-of-range reads still answer, with zero data
                    rsp_rdata[int'(gnt_idx)*DATA_W +: DATA_W] <=
                        gnt_in_range ? mem[gnt_addr] : '0;
                end
            end
        end
    end

    // Count cycles with two or more requesters; stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contend_cnt <= '0;
        end else if ($countones(req_valid) >= 2 && contend_cnt != '1) begin
            contend_cnt <= contend_cnt + 1'b1;
        end
    end

endmodule
